// File: rtl/lcd_win_pkg.sv
// Shared types for the LCD window controller: command codes, FSM states and a width helper.
package lcd_win_pkg;

  typedef enum logic [2:0] {
    CMD_REFLASH  = 3'd0,
    CMD_LOAD     = 3'd1,
    CMD_RIGHT    = 3'd2,
    CMD_LEFT     = 3'd3,
    CMD_UP       = 3'd4,
    CMD_DOWN     = 3'd5,
    CMD_MIRROR_H = 3'd6,
    CMD_MIRROR_V = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OUT
  } state_e;

  // Bits needed to index a range of n values, never less than one.
  function automatic int unsigned width_of(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_win_addr.sv
// Window pixel address generator: origin, window row/col and mirror flags in, buffer index out.
module lcd_win_addr #(
  parameter int unsigned IMG_W = 6,
  parameter int unsigned WIN   = 3,
  parameter int unsigned OX_W  = 3,
  parameter int unsigned OY_W  = 3,
  parameter int unsigned RC_W  = 2,
  parameter int unsigned IDX_W = 6
) (
  input  logic [OX_W-1:0]  i_ox,
  input  logic [OY_W-1:0]  i_oy,
  input  logic [RC_W-1:0]  i_row,
  input  logic [RC_W-1:0]  i_col,
  input  logic             i_mirror_h,
  input  logic             i_mirror_v,
  output logic [IDX_W-1:0] o_idx
);

  logic [RC_W-1:0] w_row_eff;
  logic [RC_W-1:0] w_col_eff;

  assign w_row_eff = i_mirror_v ? (RC_W'(WIN - 1) - i_row) : i_row;
  assign w_col_eff = i_mirror_h ? (RC_W'(WIN - 1) - i_col) : i_col;

  // The true index is always below 2**IDX_W, so modular IDX_W-bit arithmetic is exact
  // even when IMG_W itself needs one more bit (only possible for a single-row frame).
  assign o_idx = (IDX_W'(i_oy) + IDX_W'(w_row_eff)) * IDX_W'(IMG_W)
               + IDX_W'(i_ox) + IDX_W'(w_col_eff);

endmodule

// File: rtl/lcd_win_ctrl.sv
// Frame buffer + shiftable WIN x WIN window streamer for the LCD driver.
// Define LCD_WIN_MIRROR_EN to enable the MIRROR_H / MIRROR_V commands.
module lcd_win_ctrl
  import lcd_win_pkg::*;
#(
  parameter int unsigned IMG_W  = 6,
  parameter int unsigned IMG_H  = 6,
  parameter int unsigned WIN    = 3,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] datain,
  input  logic [2:0]        cmd,
  input  logic              cmd_valid,
  output logic [DATA_W-1:0] dataout,
  output logic              output_valid,
  output logic              busy
);

  localparam int unsigned N     = IMG_W * IMG_H;
  localparam int unsigned IDX_W = width_of(N);
  localparam int unsigned OX_W  = width_of(IMG_W);
  localparam int unsigned OY_W  = width_of(IMG_H);
  localparam int unsigned RC_W  = width_of(WIN);

  localparam logic [OX_W-1:0]  OX_MAX   = OX_W'(IMG_W - WIN);
  localparam logic [OY_W-1:0]  OY_MAX   = OY_W'(IMG_H - WIN);
  localparam logic [OX_W-1:0]  OX_HOME  = OX_W'(IMG_W / 2 - WIN / 2);
  localparam logic [OY_W-1:0]  OY_HOME  = OY_W'(IMG_H / 2 - WIN / 2);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(WIN - 1);
  localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(N - 1);

  state_e            r_state;
  state_e            w_state_next;
  logic [DATA_W-1:0] r_buf [N];
  logic [IDX_W-1:0]  r_pix;
  logic [RC_W-1:0]   r_row;
  logic [RC_W-1:0]   r_col;
  logic [OX_W-1:0]   r_ox;
  logic [OY_W-1:0]   r_oy;
  logic [DATA_W-1:0] r_dataout;
  logic              r_output_valid;

  cmd_e              w_cmd;
  logic              w_cmd_ok;
  logic              w_accept;
  logic              w_load_last;
  logic              w_out_last;
  logic              w_mirror_h;
  logic              w_mirror_v;
  logic [IDX_W-1:0]  w_idx;

  assign w_cmd = cmd_e'(cmd);

`ifdef LCD_WIN_MIRROR_EN
  logic r_mirror_h;
  logic r_mirror_v;
  assign w_mirror_h = r_mirror_h;
  assign w_mirror_v = r_mirror_v;
  assign w_cmd_ok   = 1'b1;
`else
  assign w_mirror_h = 1'b0;
  assign w_mirror_v = 1'b0;
  // Mirror codes are never accepted, so they raise no busy and produce no output.
  assign w_cmd_ok   = (w_cmd != CMD_MIRROR_H) && (w_cmd != CMD_MIRROR_V);
`endif

  // Stay busy through the final valid pixel so busy drops one edge after the last output.
  assign busy         = (r_state != ST_IDLE) || r_output_valid;
  assign w_accept     = cmd_valid && !busy && w_cmd_ok;
  assign w_load_last  = (r_pix == PIX_LAST);
  assign w_out_last   = (r_row == RC_LAST) && (r_col == RC_LAST);
  assign dataout      = r_dataout;
  assign output_valid = r_output_valid;

  lcd_win_addr #(
    .IMG_W (IMG_W),
    .WIN   (WIN),
    .OX_W  (OX_W),
    .OY_W  (OY_W),
    .RC_W  (RC_W),
    .IDX_W (IDX_W)
  ) u_addr (
    .i_ox       (r_ox),
    .i_oy       (r_oy),
    .i_row      (r_row),
    .i_col      (r_col),
    .i_mirror_h (w_mirror_h),
    .i_mirror_v (w_mirror_v),
    .o_idx      (w_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_next and no latch is inferred.
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = (w_cmd == CMD_LOAD) ? ST_LOAD : ST_OUT;
      ST_LOAD: if (w_load_last) w_state_next = ST_OUT;
      ST_OUT:  if (w_out_last) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the frame buffer is cleared on reset so REFLASH before any LOAD shows zeros.
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
      r_pix          <= '0;
      r_row          <= '0;
      r_col          <= '0;
      r_ox           <= OX_HOME;
      r_oy           <= OY_HOME;
      r_dataout      <= '0;
      r_output_valid <= 1'b0;
`ifdef LCD_WIN_MIRROR_EN
      r_mirror_h     <= 1'b0;
      r_mirror_v     <= 1'b0;
`endif
    end else begin
      r_output_valid <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_pix <= '0;
          r_row <= '0;
          r_col <= '0;
          case (w_cmd)
            CMD_LOAD: begin
              r_ox <= OX_HOME;
              r_oy <= OY_HOME;
`ifdef LCD_WIN_MIRROR_EN
              r_mirror_h <= 1'b0;
              r_mirror_v <= 1'b0;
`endif
            end
            CMD_RIGHT: if (r_ox < OX_MAX) r_ox <= r_ox + 1'b1;
            CMD_LEFT:  if (r_ox != '0)    r_ox <= r_ox - 1'b1;
            CMD_UP:    if (r_oy != '0)    r_oy <= r_oy - 1'b1;
            CMD_DOWN:  if (r_oy < OY_MAX) r_oy <= r_oy + 1'b1;
`ifdef LCD_WIN_MIRROR_EN
            CMD_MIRROR_H: r_mirror_h <= !r_mirror_h;
            CMD_MIRROR_V: r_mirror_v <= !r_mirror_v;
`endif
            default: ;
          endcase
        end
        ST_LOAD: begin
          r_buf[r_pix] <= datain;
          r_pix        <= r_pix + 1'b1;
        end
        ST_OUT: begin
          r_dataout      <= r_buf[w_idx];
          r_output_valid <= 1'b1;
          if (r_col == RC_LAST) begin
            r_col <= '0;
            r_row <= r_row + 1'b1;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_win_ctrl.sv
// Scoreboard bench for lcd_win_ctrl (6x6 frame, 3x3 window, 8-bit pixels); follows LCD_WIN_MIRROR_EN.
module tb_lcd_win_ctrl;

  localparam int IMG_W  = 6;
  localparam int IMG_H  = 6;
  localparam int WIN    = 3;
  localparam int DATA_W = 8;
  localparam int N      = IMG_W * IMG_H;
  localparam int NW     = WIN * WIN;
`ifdef LCD_WIN_MIRROR_EN
  localparam bit MIRROR_EN = 1'b1;
`else
  localparam bit MIRROR_EN = 1'b0;
`endif

  logic              clk       = 1'b0;
  logic              reset     = 1'b1;
  logic [DATA_W-1:0] datain    = '0;
  logic [2:0]        cmd       = '0;
  logic              cmd_valid = 1'b0;
  logic [DATA_W-1:0] dataout;
  logic              output_valid;
  logic              busy;

  lcd_win_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .WIN    (WIN),
    .DATA_W (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .datain       (datain),
    .cmd          (cmd),
    .cmd_valid    (cmd_valid),
    .dataout      (dataout),
    .output_valid (output_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int frame[N];
  int m_ox, m_oy;
  bit m_mh, m_mv;
  bit use_ramp;
  int last_out = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: frame contents, origin and mirror flags kept as plain integers.
  task automatic model_reset();
    for (int i = 0; i < N; i++) frame[i] = 0;
    m_ox = IMG_W / 2 - WIN / 2;
    m_oy = IMG_H / 2 - WIN / 2;
    m_mh = 1'b0;
    m_mv = 1'b0;
  endtask

  task automatic model_cmd(input int code);
    case (code)
      1: begin
        for (int i = 0; i < N; i++) frame[i] = use_ramp ? i : int'($urandom_range(0, 255));
        m_ox = IMG_W / 2 - WIN / 2;
        m_oy = IMG_H / 2 - WIN / 2;
        m_mh = 1'b0;
        m_mv = 1'b0;
      end
      2: if (m_ox < IMG_W - WIN) m_ox++;
      3: if (m_ox > 0) m_ox--;
      4: if (m_oy > 0) m_oy--;
      5: if (m_oy < IMG_H - WIN) m_oy++;
      6: m_mh = !m_mh;
      7: m_mv = !m_mv;
      default: ;
    endcase
  endtask

  task automatic push_window();
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        int rr, cc;
        rr = m_mv ? (WIN - 1 - r) : r;
        cc = m_mh ? (WIN - 1 - c) : c;
        exp_q.push_back(frame[(m_oy + rr) * IMG_W + (m_ox + cc)]);
      end
    end
  endtask

  // Monitor: every valid pixel is popped against the scoreboard; idle cycles must hold dataout.
  always @(negedge clk) begin
    if (reset) begin
      last_out = 0;
    end else if (output_valid) begin
      if (exp_q.size() == 0) check("unexpected_valid", output_valid, 1'b0);
      else                   check("pixel", dataout, exp_q.pop_front());
      last_out = dataout;
    end else begin
      check("dataout_hold", dataout, last_out);
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    check("idle_timeout", busy, 1'b0);
  endtask

  task automatic issue(input logic [2:0] code, input bit glitch);
    int k, kstart, lat;
    bit ok;
    wait_idle();
    ok = MIRROR_EN || (code < 3'd6);
    cmd       = code;
    cmd_valid = 1'b1;
    if (ok && code != 3'd1) begin
      model_cmd(int'(code));
      push_window();
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd       = 3'($urandom_range(0, 7));
    if (!ok) begin
      for (int i = 0; i < 3; i++) begin
        check("ignored_busy", busy, 1'b0);
        @(posedge clk); #1;
      end
      return;
    end
    check("busy_rise", busy, 1'b1);
    k = 0;
    if (code == 3'd1) begin
      model_cmd(1);
      for (int i = 0; i < N; i++) begin
        datain = DATA_W'(frame[i]);
        @(posedge clk); #1;
        k++;
      end
      datain = DATA_W'($urandom_range(0, 255));
      push_window();
      lat = N + NW + 1;
    end else begin
      lat = NW + 1;
    end
    kstart = k;
    while (busy && k < lat + 20) begin
      if (glitch && k == kstart + 3) begin
        cmd       = 3'($urandom_range(0, 7));
        cmd_valid = 1'b1;
      end else begin
        cmd_valid = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    cmd_valid = 1'b0;
    check("busy_cycles", k, lat);
  endtask

  task automatic reset_mid_load();
    wait_idle();
    cmd       = 3'd1;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      datain = DATA_W'($urandom_range(1, 255));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_dataout", dataout, 0);
    check("rst_mid_valid", output_valid, 1'b0);
    check("rst_mid_busy", busy, 1'b0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

  initial begin
    model_reset();
    use_ramp = 1'b1;
    reset    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_dataout", dataout, 0);
    check("reset_valid", output_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;

    // REFLASH straight after reset, with a cmd_valid pulse during the output burst.
    issue(3'd0, 1'b1);

    // Ramp frame, then two RIGHT shifts (second clamps).
    issue(3'd1, 1'b0);
    issue(3'd2, 1'b0);
    issue(3'd2, 1'b0);

    // Reload, then walk to the top-left corner and beyond.
    issue(3'd1, 1'b0);
    repeat (3) issue(3'd3, 1'b0);
    repeat (3) issue(3'd4, 1'b0);

    // Reload, then horizontal and vertical mirror (ignored codes when the feature is off).
    issue(3'd1, 1'b0);
    issue(3'd6, 1'b0);
    issue(3'd7, 1'b0);
    issue(3'd5, 1'b0);

    // Abort a load with reset; buffer must read back as zeros.
    reset_mid_load();
    issue(3'd0, 1'b0);
    issue(3'd2, 1'b0);

    // Random command mix with random frames.
    use_ramp = 1'b0;
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_win_ctrl.md
# lcd_win_ctrl

Parametrised image display controller. Loads an IMG_W×IMG_H pixel frame over a serial byte stream, holds it in an internal buffer, and streams out a WIN×WIN display window. The window can be shifted within the frame and, optionally, mirrored. Sits between the host command interface and the LCD driver. Generalises the fixed 6×6/3×3 controller to arbitrary frame size, window size and pixel width.

## Interface
- IMG_W, 6, frame width in pixels (≥ WIN)
- IMG_H, 6, frame height in pixels (≥ WIN)
- WIN, 3, window edge length in pixels (≥ 1)
- DATA_W, 8, pixel width in bits
- clk  input  1  single clock, all logic on rising edge
- reset  input  1  synchronous, active-high
- datain  input  DATA_W  pixel stream during load
- cmd  input  3  command code
- cmd_valid  input  1  cmd qualifier
- dataout  output  DATA_W  window pixel
- output_valid  output  1  dataout qualifier
- busy  output  1  command in progress; cmd ignored while high

## Operation
- Command accepted on an edge where cmd_valid=1 and busy=0. Otherwise cmd is ignored.
- Codes:
  - 0 REFLASH: output the window.
  - 1 LOAD: receive a frame, reset origin and mirror flags, then output the window.
  - 2 RIGHT: ox+1.
  - 3 LEFT: ox−1.
  - 4 UP: oy−1.
  - 5 DOWN: oy+1.
  - 6 MIRROR_H: toggle mirror_h.
  - 7 MIRROR_V: toggle mirror_v.
  - Codes 2–7 apply their update, then output the window.
- Origin (ox, oy) is the top-left window pixel.
  - ox clamps to [0, IMG_W−WIN]; oy clamps to [0, IMG_H−WIN].
  - A shift at the limit leaves the origin unchanged but still outputs the window.
- Home origin is (IMG_W/2 − WIN/2, IMG_H/2 − WIN/2), integer division. It is applied on reset and on LOAD.
- LOAD frame order: raster order, row 0 first, left to right. Buffer index = row·IMG_W + col.
- Window output order: row-major, r = 0..WIN−1, c = 0..WIN−1.
  - Pixel fetched is buffer[(oy + r')·IMG_W + (ox + c')].
  - r' = mirror_v ? WIN−1−r : r; c' = mirror_h ? WIN−1−c : c.
- Mirror flags persist across REFLASH and shifts. They are cleared by reset and by LOAD.
- FSM states:
  - IDLE → LOAD (cmd 1) or OUT (all other accepted cmds).
  - LOAD → OUT after IMG_W·IMG_H pixels.
  - OUT → IDLE after WIN² pixels.
- Counter widths are $clog2 of each range. Index arithmetic is at least $clog2(IMG_W·IMG_H) bits with no truncation.

## Timing
- Reset values:
  - dataout=0, output_valid=0, busy=0.
  - Buffer all zero; origin at home; mirror flags 0; FSM in IDLE.
- Let T be the accepting edge. busy=1 from edge T.
- Non-load commands:
  - output_valid=1 on edges T+1 … T+WIN², one pixel per cycle with no gaps.
  - Edge T+WIN²+1: output_valid=0, busy=0. A new command may be accepted on the following edge.
- LOAD:
  - datain is sampled on edges T+1 … T+N, where N = IMG_W·IMG_H.
  - output_valid=1 on edges T+N+1 … T+N+WIN².
  - busy falls at T+N+WIN²+1.
- dataout holds its last value while output_valid=0.
- REFLASH before any LOAD outputs zeros.
- Reset asserted mid-LOAD or mid-OUT aborts on that edge. All reset values apply, including buffer clear.
- cmd_valid held high through busy has no effect. Only the first accepted command executes.

## Configuration
- LCD_WIN_MIRROR_EN defined:
  - Codes 6/7 behave as above.
- LCD_WIN_MIRROR_EN undefined:
  - Mirror flags and their logic are removed; r'=r, c'=c.
  - Codes 6/7 are ignored: busy stays 0 and nothing is output.

## Structure
- Package lcd_win_pkg holds:
  - the command code constants/enum (CMD_REFLASH … CMD_MIRROR_V);
  - the FSM state typedef (ST_IDLE, ST_LOAD, ST_OUT).
- Sub-module lcd_win_addr: combinational; ox, oy, r, c and mirror flags in, buffer index out. Reused by the next-generation zoom block.

## Test plan
All scenarios use defaults: IMG 6×6, WIN 3, DATA_W 8.
- LOAD with datain = 0..35 → after 36 input cycles, 9 valid pixels 14,15,16,20,21,22,26,27,28; busy low at T+46.
- After load, RIGHT twice → first output 15,16,17,21,22,23,27,28,29; second output identical (clamped at ox=3).
- After load, LEFT ×3 and UP ×3 → final window 0,1,2,6,7,8,12,13,14; busy pulses 10 cycles per command.
- After load, MIRROR_H then MIRROR_V → first output 16,15,14,22,21,20,28,27,26; second output 28,27,26,22,21,20,16,15,14.
- REFLASH straight after reset → 9 zeros. cmd_valid pulsed mid-output → ignored, output sequence unchanged.
- Reset asserted at pixel 20 of LOAD → outputs 0 next edge; subsequent REFLASH gives zeros, origin back at (2,2).
